stat_engine: RTL and testbench

//  Pet-stat engine. Reads player buttons and the 4-bit random value, and holds the six pet stats.

---
 rtl/stat_engine.sv | 206 ++++++++++++++++++++
 tb/tb_stat_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stat_engine.sv
// Pet-stat engine: synced/debounced care buttons, prescaled decay, action FSM with cooldown.
// Raw press to APPLY is 3 + DEBOUNCE_CYCLES cycles; presses arriving while busy are dropped, never queued.
module stat_engine #(
    parameter logic [23:0] MAX_COUNT       = 24'd10_000_000,
    parameter logic [3:0]  DECAY_TICKS     = 4'd4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
    parameter logic [3:0]  COOLDOWN_TICKS  = 4'd2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] buttons_i,
    input  logic [3:0] rand_in_i,
    output logic [3:0] hunger_o,
    output logic [3:0] happiness_o,
    output logic [3:0] health_o,
    output logic [3:0] hygiene_o,
    output logic [3:0] energy_o,
    output logic [3:0] social_o,
    output logic       tick_o,
    output logic       busy_o,
    output logic [2:0] last_action_o
);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COOLDOWN} state_t;

    typedef struct packed {
        logic [3:0] hunger;
        logic [3:0] happiness;
        logic [3:0] health;
        logic [3:0] hygiene;
        logic [3:0] energy;
        logic [3:0] social;
    } stats_t;

    localparam logic [2:0] A_FEED  = 3'd1;
    localparam logic [2:0] A_PLAY  = 3'd2;
    localparam logic [2:0] A_CLEAN = 3'd3;
    localparam logic [2:0] A_SLEEP = 3'd4;
    localparam logic [2:0] A_MED   = 3'd5;
    localparam logic [2:0] A_PET   = 3'd6;

    function automatic logic [3:0] sat_add(input logic [3:0] v, input logic [3:0] n);
        logic [4:0] s;
        s = {1'b0, v} + {1'b0, n};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    // Borrow out of the 5-bit difference lands in bit 4, which means "went below zero".
    function automatic logic [3:0] sat_sub(input logic [3:0] v, input logic [3:0] n);
        logic [4:0] s;
        s = {1'b0, v} - {1'b0, n};
        return s[4] ? 4'h0 : s[3:0];
    endfunction

    logic [5:0]        sync1_q, sync2_q;
    logic [5:0][15:0]  deb_q, deb_d;
    logic [5:0]        level, level_q, req;
    logic [2:0]        req_code;
    logic [23:0]       presc_q, presc_d;
    logic [3:0]        dec_cnt_q, dec_cnt_d;
    logic [3:0]        cd_q, cd_d;
    logic [2:0]        last_action_q, last_action_d;
    state_t            state_q, state_d;
    stats_t            st_q, st_d, dec_s;
    logic              tick, decay_step;
    logic              unused_bits;

    assign unused_bits = ^buttons_i[7:6];

    always_comb begin
        deb_d    = deb_q;
        req_code = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!sync2_q[i])
                deb_d[i] = 16'd0;
            else if (deb_q[i] != DEBOUNCE_CYCLES)
                deb_d[i] = deb_q[i] + 16'd1;
        end
        // Scan downwards so the lowest simultaneous request wins.
        for (int i = 5; i >= 0; i--) begin
            if (req[i])
                req_code = 3'(i + 1);
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++)
            level[i] = (deb_q[i] == DEBOUNCE_CYCLES);
    end

    assign req        = level & ~level_q;
    assign tick       = (presc_q == MAX_COUNT - 24'd1);
    assign decay_step = tick && (dec_cnt_q == DECAY_TICKS - 4'd1);

    always_comb begin
        presc_d   = tick ? 24'd0 : presc_q + 24'd1;
        dec_cnt_d = dec_cnt_q;
        if (tick)
            dec_cnt_d = decay_step ? 4'd0 : dec_cnt_q + 4'd1;
    end

    always_comb begin
        state_d       = state_q;
        cd_d          = cd_q;
        last_action_d = last_action_q;
        case (state_q)
            S_IDLE: begin
                if (req_code != 3'd0) begin
                    state_d       = S_APPLY;
                    last_action_d = req_code;
                end
            end
            S_APPLY: begin
                state_d = S_COOLDOWN;
                cd_d    = 4'd0;
            end
            S_COOLDOWN: begin
                if (cd_q == COOLDOWN_TICKS)
                    state_d = S_IDLE;
                else if (tick)
                    cd_d = cd_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decay is evaluated first on the current stats; the action then works on the decayed values.
    always_comb begin
        dec_s = st_q;
        if (decay_step) begin
            dec_s.hunger  = sat_sub(st_q.hunger, 4'd1);
            dec_s.hygiene = sat_sub(st_q.hygiene, 4'd1);
            dec_s.energy  = sat_sub(st_q.energy, 4'd1);
            dec_s.social  = sat_sub(st_q.social, 4'd1);
            if (rand_in_i[0])
                dec_s.happiness = sat_sub(st_q.happiness, 4'd1);
            if (st_q.hunger == 4'd0 || st_q.hygiene == 4'd0 || rand_in_i == 4'hF)
                dec_s.health = sat_sub(st_q.health, 4'd1);
        end
        st_d = dec_s;
        if (state_q == S_APPLY) begin
            case (last_action_q)
                A_FEED: begin
                    st_d.hunger  = sat_add(dec_s.hunger, 4'd4);
                    st_d.hygiene = sat_sub(dec_s.hygiene, 4'd1);
                end
                A_PLAY: begin
                    st_d.happiness = sat_add(dec_s.happiness, 4'd3);
                    st_d.energy    = sat_sub(dec_s.energy, 4'd2);
                    st_d.social    = sat_add(dec_s.social, 4'd1);
                end
                A_CLEAN: st_d.hygiene = 4'hF;
                A_SLEEP: begin
                    st_d.energy = sat_add(dec_s.energy, 4'd5);
                    st_d.hunger = sat_sub(dec_s.hunger, 4'd1);
                end
                A_MED: begin
                    st_d.health    = sat_add(dec_s.health, 4'd4);
                    st_d.happiness = sat_sub(dec_s.happiness, 4'd1);
                end
                A_PET: begin
                    st_d.social    = sat_add(dec_s.social, 4'd3);
                    st_d.happiness = sat_add(dec_s.happiness, 4'd1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            level_q       <= '0;
            presc_q       <= '0;
            dec_cnt_q     <= '0;
            cd_q          <= '0;
            last_action_q <= '0;
            state_q       <= S_IDLE;
            st_q          <= '{4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12};
        end else begin
            sync1_q       <= buttons_i[5:0];
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            level_q       <= level;
            presc_q       <= presc_d;
            dec_cnt_q     <= dec_cnt_d;
            cd_q          <= cd_d;
            last_action_q <= last_action_d;
            state_q       <= state_d;
            st_q          <= st_d;
        end
    end

    assign hunger_o      = st_q.hunger;
    assign happiness_o   = st_q.happiness;
    assign health_o      = st_q.health;
    assign hygiene_o     = st_q.hygiene;
    assign energy_o      = st_q.energy;
    assign social_o      = st_q.social;
    assign tick_o        = tick;
    assign busy_o        = (state_q != S_IDLE);
    assign last_action_o = last_action_q;

endmodule

// File: tb/tb_stat_engine.sv
// Directed bench for stat_engine with short prescaler/debounce/cooldown settings.
module tb_stat_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buttons;
    logic [3:0] rand_in;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic       tick, busy;
    logic [2:0] last_action;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    stat_engine #(
        .MAX_COUNT      (24'd4),
        .DECAY_TICKS    (4'd2),
        .DEBOUNCE_CYCLES(16'd3),
        .COOLDOWN_TICKS (4'd1)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .buttons_i    (buttons),
        .rand_in_i    (rand_in),
        .hunger_o     (hunger),
        .happiness_o  (happiness),
        .health_o     (health),
        .hygiene_o    (hygiene),
        .energy_o     (energy),
        .social_o     (social),
        .tick_o       (tick),
        .busy_o       (busy),
        .last_action_o(last_action)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] mask;
        int         start;
        int         hold;
        logic [3:0] rnd;
        int         chk;
        logic [3:0] hu, ha, he, hy, en, so;
        logic [2:0] la;
        logic       bsy, tck;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) step();
    endtask

    // Leaves the bench 1ns into cycle 1, the first cycle out of reset.
    task automatic do_reset();
        reset   = 1'b1;
        buttons = 8'h00;
        rand_in = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 1;
    endtask

    task automatic drive(input logic [7:0] m, input int s, input int h);
        buttons = (cyc >= s && cyc < s + h) ? m : 8'h00;
    endtask

    task automatic check_stats(input string nm, input logic [3:0] hu, input logic [3:0] ha,
                               input logic [3:0] he, input logic [3:0] hy,
                               input logic [3:0] en, input logic [3:0] so);
        check({nm, ".hunger"},    hunger,    hu);
        check({nm, ".happiness"}, happiness, ha);
        check({nm, ".health"},    health,    he);
        check({nm, ".hygiene"},   hygiene,   hy);
        check({nm, ".energy"},    energy,    en);
        check({nm, ".social"},    social,    so);
    endtask

    initial begin
        int nt;
        reset   = 1'b1;
        buttons = 8'h00;
        rand_in = 4'h0;

        //           name         mask  st hd rnd chk  hu  ha  he  hy  en  so  la bsy tck
        vecs[0]  = '{"reset",     8'h00, 1, 0, 4'h0, 1, 12, 12, 12, 12, 12, 12, 0, 0, 0};
        vecs[1]  = '{"feed",      8'h01, 1,10, 4'h0, 8, 15, 12, 12, 11, 12, 12, 1, 1, 1};
        vecs[2]  = '{"play",      8'h02, 1,10, 4'h0, 8, 12, 15, 12, 12, 10, 13, 2, 1, 1};
        vecs[3]  = '{"clean",     8'h04, 1,10, 4'h0, 8, 12, 12, 12, 15, 12, 12, 3, 1, 1};
        vecs[4]  = '{"sleep",     8'h08, 1,10, 4'h0, 8, 11, 12, 12, 12, 15, 12, 4, 1, 1};
        vecs[5]  = '{"medicine",  8'h10, 1,10, 4'h0, 8, 12, 11, 15, 12, 12, 12, 5, 1, 1};
        vecs[6]  = '{"pet",       8'h20, 1,10, 4'h0, 8, 12, 13, 12, 12, 12, 15, 6, 1, 1};
        vecs[7]  = '{"clean_med", 8'h14, 1,10, 4'h0, 8, 12, 12, 12, 15, 12, 12, 3, 1, 1};
        vecs[8]  = '{"all_six",   8'h3F, 1,10, 4'h0, 8, 15, 12, 12, 11, 12, 12, 1, 1, 1};
        vecs[9]  = '{"pulse2",    8'h02, 1, 2, 4'h0, 8, 12, 12, 12, 12, 12, 12, 0, 0, 1};
        vecs[10] = '{"high_bits", 8'hC0, 1,10, 4'h0, 8, 12, 12, 12, 12, 12, 12, 0, 0, 1};
        vecs[11] = '{"decay_r0",  8'h00, 1, 0, 4'h0, 9, 11, 12, 12, 11, 11, 11, 0, 0, 0};
        vecs[12] = '{"decay_r1",  8'h00, 1, 0, 4'h1, 9, 11, 11, 12, 11, 11, 11, 0, 0, 0};
        vecs[13] = '{"decay_rF",  8'h00, 1, 0, 4'hF, 9, 11, 11, 11, 11, 11, 11, 0, 0, 0};
        vecs[14] = '{"feed_decay",8'h01, 2,10, 4'h0, 9, 15, 12, 12, 10, 11, 11, 1, 1, 0};

        foreach (vecs[i]) begin
            do_reset();
            rand_in = vecs[i].rnd;
            drive(vecs[i].mask, vecs[i].start, vecs[i].hold);
            while (cyc < vecs[i].chk) begin
                step();
                drive(vecs[i].mask, vecs[i].start, vecs[i].hold);
            end
            @(negedge clk);
            check_stats(vecs[i].name, vecs[i].hu, vecs[i].ha, vecs[i].he,
                        vecs[i].hy, vecs[i].en, vecs[i].so);
            check({vecs[i].name, ".last_action"}, last_action, vecs[i].la);
            check({vecs[i].name, ".busy"}, busy, vecs[i].bsy);
            check({vecs[i].name, ".tick"}, tick, vecs[i].tck);
        end

        // Idle run: tick count and two decay steps over 16 cycles.
        do_reset();
        nt = 0;
        for (int c = 1; c <= 16; c++) begin
            goto(c);
            @(negedge clk);
            if (tick === 1'b1) nt++;
        end
        check("idle.ticks", 8'(nt), 8'd4);
        goto(17);
        @(negedge clk);
        check_stats("idle16", 10, 12, 12, 10, 10, 10);

        // Held feed: busy window, then exactly one application over many cycles.
        do_reset();
        buttons = 8'h01;
        goto(9);
        @(negedge clk);
        check("held.busy_c9", busy, 1);
        goto(10);
        @(negedge clk);
        check("held.busy_c10", busy, 0);
        goto(30);
        @(negedge clk);
        check("held.hunger_c30", hunger, 12);
        check("held.hygiene_c30", hygiene, 8);
        check("held.last_action", last_action, 1);

        // Play, pet pressed during the busy window is dropped, a later pet is applied.
        do_reset();
        for (int c = 1; c <= 22; c++) begin
            goto(c);
            buttons = ((c <= 10) ? 8'h02 : 8'h00) |
                      (((c >= 2 && c <= 12) || c >= 14) ? 8'h20 : 8'h00);
            if (c == 14) begin
                @(negedge clk);
                check("cool.social_c14", social, 12);
                check("cool.happy_c14", happiness, 15);
                check("cool.la_c14", last_action, 2);
                check("cool.busy_c14", busy, 0);
            end
        end
        @(negedge clk);
        check("cool.social_c22", social, 14);
        check("cool.happy_c22", happiness, 15);
        check("cool.la_c22", last_action, 6);
        check("cool.busy_c22", busy, 1);

        // Long decay to floor; health loses at most one per step.
        do_reset();
        goto(105);
        @(negedge clk);
        check_stats("floor_c105", 0, 12, 11, 0, 0, 0);
        rand_in = 4'hF;
        goto(113);
        @(negedge clk);
        check_stats("floor_c113", 0, 11, 10, 0, 0, 0);

        // Reset asserted in the middle of cooldown.
        do_reset();
        buttons = 8'h01;
        goto(8);
        @(negedge clk);
        check("rst_mid.busy_before", busy, 1);
        check("rst_mid.hunger_before", hunger, 15);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("rst_mid.busy", busy, 0);
        check_stats("rst_mid", 12, 12, 12, 12, 12, 12);
        check("rst_mid.last_action", last_action, 0);
        reset   = 1'b0;
        buttons = 8'h00;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
